// File: rtl/addroundkey_sched.sv
// AddRoundKey stage with a writable round-key store, configurable round count and a
// single-entry valid/ready output register carrying round index, last and error flags.
module addroundkey_sched #(
  parameter int unsigned WORD   = 32,
  parameter int unsigned NB     = 4,
  parameter int unsigned NR_MAX = 14,
  parameter int unsigned RW     = $clog2(NR_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_key_we,
  input  logic [RW-1:0]        i_key_idx,
  input  logic [WORD*NB-1:0]   i_key,
  input  logic                 i_cfg_we,
  input  logic [RW-1:0]        i_cfg_nr,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD*NB-1:0]   i_block,
  input  logic [RW-1:0]        i_round,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD*NB-1:0]   o_block,
  output logic [RW-1:0]        o_round,
  output logic                 o_last,
  output logic                 o_err
);

  localparam int unsigned W = WORD * NB;
  localparam logic [RW-1:0] NrMax   = RW'(NR_MAX);
  localparam logic [RW-1:0] NrReset = RW'(10);

  logic [W-1:0]  key_q [NR_MAX+1];
  logic [W-1:0]  key_sel;
  logic [RW-1:0] nr_q;

  logic          valid_q, valid_d;
  logic [W-1:0]  block_q, block_d;
  logic [RW-1:0] round_q, round_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          accept;

  // Slots beyond NR_MAX have no matching index, so such writes fall away.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= int'(NR_MAX); i++) key_q[i] <= '0;
    end else begin
      for (int i = 0; i <= int'(NR_MAX); i++) begin
        if (i_key_we && (i_key_idx == RW'(i))) key_q[i] <= i_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      nr_q <= NrReset;
    end else if (i_cfg_we && (i_cfg_nr != '0) && (i_cfg_nr <= NrMax)) begin
      nr_q <= i_cfg_nr;
    end
  end

  // Read mux sees the pre-write key, giving old-key semantics on a same-cycle collision.
  always_comb begin
    key_sel = '0;
    for (int i = 0; i <= int'(NR_MAX); i++) begin
      if (i_round == RW'(i)) key_sel = key_q[i];
    end
  end

  assign o_ready = !rst || !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  always_comb begin
    valid_d = valid_q;
    block_d = block_q;
    round_d = round_q;
    last_d  = last_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      round_d = i_round;
      last_d  = (i_round == nr_q);
      if (i_round > nr_q) begin
        block_d = i_block;
        err_d   = 1'b1;
      end else begin
        block_d = i_block ^ key_sel;
        err_d   = 1'b0;
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      block_q <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      block_q <= block_d;
      round_q <= round_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign o_valid = valid_q;
  assign o_block = block_q;
  assign o_round = round_q;
  assign o_last  = last_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_addroundkey_sched.sv
// Directed self-checking bench for addroundkey_sched: FIPS-197 round 0, backpressure,
// last/error flags, key and cfg write collisions, and mid-stream reset.
module tb_addroundkey_sched;

  localparam int unsigned RW = 4;
  localparam int unsigned W  = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_key_we;
  logic [RW-1:0] i_key_idx;
  logic [W-1:0]  i_key;
  logic          i_cfg_we;
  logic [RW-1:0] i_cfg_nr;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_block;
  logic [RW-1:0] i_round;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_block;
  logic [RW-1:0] o_round;
  logic          o_last;
  logic          o_err;

  int tests = 0;
  int fails = 0;

  addroundkey_sched dut (
    .clk       (clk),
    .rst       (rst),
    .i_key_we  (i_key_we),
    .i_key_idx (i_key_idx),
    .i_key     (i_key),
    .i_cfg_we  (i_cfg_we),
    .i_cfg_nr  (i_cfg_nr),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_block   (i_block),
    .i_round   (i_round),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_block   (o_block),
    .o_round   (o_round),
    .o_last    (o_last),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  localparam logic [W-1:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] R0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [W-1:0] K1  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [W-1:0] K2  = 128'hf0f0f0f0_0f0f0f0f_a5a5a5a5_5a5a5a5a;
  localparam logic [W-1:0] KA  = 128'hcafebabe_deadbeef_01234567_89abcdef;
  localparam logic [W-1:0] KB  = 128'h0badf00d_feedface_76543210_fedcba98;
  localparam logic [W-1:0] B0  = 128'h00000000_00000000_00000000_000000b0;
  localparam logic [W-1:0] B1  = 128'h00000000_00000000_00000000_000000b1;
  localparam logic [W-1:0] B2  = 128'h00000000_00000000_00000000_000000b2;
  localparam logic [W-1:0] B3  = 128'h00000000_00000000_00000000_000000b3;
  localparam logic [W-1:0] BX  = 128'h13579bdf_2468ace0_fedcba98_76543210;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [RW-1:0] r, input logic [W-1:0] b);
    i_valid = 1'b1;
    i_round = r;
    i_block = b;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_key_we = 1'b0; i_key_idx = '0; i_key = '0;
    i_cfg_we = 1'b0; i_cfg_nr = '0; i_valid = 1'b0; i_block = '0;
    i_round = '0; i_ready = 1'b1;
    tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_block", o_block, 0);
    chk("rst_round", o_round, 0);
    chk("rst_last", o_last, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ready", o_ready, 1);
    rst = 1'b1;

    // Key load for slots 0..2
    i_key_we = 1'b1;
    i_key_idx = 4'd0; i_key = K0; tick();
    i_key_idx = 4'd1; i_key = K1; tick();
    i_key_idx = 4'd2; i_key = K2; tick();
    i_key_we = 1'b0;

    // FIPS-197 round 0
    beat(4'd0, P0);
    chk("fips_valid", o_valid, 1);
    chk("fips_block", o_block, R0);
    chk("fips_last", o_last, 0);
    chk("fips_err", o_err, 0);
    tick();
    chk("fips_drain", o_valid, 0);

    // Backpressure: beat 0 lands, then 3 stalled cycles with beat 1 waiting
    i_valid = 1'b1; i_round = 4'd0; i_block = B0; tick();
    chk("bp_b0", o_block, B0 ^ K0);
    i_round = 4'd1; i_block = B1; i_ready = 1'b0; #1;
    chk("bp_ready0", o_ready, 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_stall_ready", o_ready, 0);
      chk("bp_stall_valid", o_valid, 1);
      chk("bp_stall_block", o_block, B0 ^ K0);
      chk("bp_stall_round", o_round, 0);
    end
    i_ready = 1'b1; #1;
    chk("bp_ready1", o_ready, 1);
    tick();
    chk("bp_r1", o_round, 1);
    chk("bp_b1", o_block, B1 ^ K1);
    i_round = 4'd2; i_block = B2; tick();
    chk("bp_r2", o_round, 2);
    chk("bp_b2", o_block, B2 ^ K2);
    i_round = 4'd3; i_block = B3; tick();
    chk("bp_r3", o_round, 3);
    chk("bp_b3", o_block, B3);
    i_valid = 1'b0; tick();
    chk("bp_drain", o_valid, 0);

    // Last / error flags, nr=10 from reset
    beat(4'd10, BX);
    chk("nr10_last", o_last, 1);
    chk("nr10_err", o_err, 0);
    chk("nr10_block", o_block, BX);
    i_cfg_we = 1'b1; i_cfg_nr = 4'd14; tick(); i_cfg_we = 1'b0;
    beat(4'd10, BX);
    chk("nr14_r10_last", o_last, 0);
    beat(4'd14, BX);
    chk("nr14_r14_last", o_last, 1);
    chk("nr14_r14_err", o_err, 0);
    i_cfg_we = 1'b1; i_cfg_nr = 4'd10; tick(); i_cfg_we = 1'b0;
    beat(4'd12, B2);
    chk("err_flag", o_err, 1);
    chk("err_block", o_block, B2);
    chk("err_last", o_last, 0);
    i_cfg_we = 1'b1; i_cfg_nr = 4'd0; tick(); i_cfg_we = 1'b0;
    beat(4'd10, BX);
    chk("cfg0_dropped", o_last, 1);
    i_cfg_we = 1'b1; i_cfg_nr = 4'd15; tick(); i_cfg_we = 1'b0;
    beat(4'd10, BX);
    chk("cfg15_dropped", o_last, 1);
    // Cfg write in the accept cycle: old nr=10 governs flags
    i_cfg_we = 1'b1; i_cfg_nr = 4'd14;
    beat(4'd14, B1);
    i_cfg_we = 1'b0;
    chk("cfgcol_err", o_err, 1);
    chk("cfgcol_last", o_last, 0);
    chk("cfgcol_block", o_block, B1);

    // Key collision on slot 3 (nr is now 14)
    i_key_we = 1'b1; i_key_idx = 4'd3; i_key = KA; tick();
    i_key = KB;
    beat(4'd3, BX);
    i_key_we = 1'b0;
    chk("keycol_old", o_block, BX ^ KA);
    beat(4'd3, BX);
    chk("keycol_new", o_block, BX ^ KB);
    i_key_we = 1'b1; i_key_idx = 4'd15; i_key = {W{1'b1}}; tick(); i_key_we = 1'b0;
    beat(4'd0, BX);
    chk("idx15_slot0", o_block, BX ^ K0);
    beat(4'd14, BX);
    chk("idx15_slot14", o_block, BX);
    beat(4'd3, BX);
    chk("idx15_slot3", o_block, BX ^ KB);

    // Reset mid-stream with a stalled beat in flight
    i_ready = 1'b0; #1;
    chk("pre_rst_valid", o_valid, 1);
    rst = 1'b0; i_valid = 1'b1; i_round = 4'd1; i_block = B1;
    i_key_we = 1'b1; i_key_idx = 4'd0; i_key = KA; #1;
    chk("rst_cycle_ready", o_ready, 1);
    tick();
    rst = 1'b1; i_valid = 1'b0; i_key_we = 1'b0; i_ready = 1'b1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_block", o_block, 0);
    beat(4'd0, BX);
    chk("postrst_key0", o_block, BX);
    chk("postrst_valid", o_valid, 1);
    beat(4'd10, B3);
    chk("postrst_nr", o_last, 1);
    chk("postrst_block", o_block, B3);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addroundkey_sched.md
# addroundkey_sched

Parametrised AddRoundKey stage with an on-chip round-key store and a valid/ready stream interface. The key expansion logic loads up to NR_MAX+1 round keys once. Each state beat carries its round index, and the block XORs the state with the matching stored key. It sits between the cipher round datapath and the round-key generator and supports AES-128/192/256 by configuration. Unlike the fixed single-key stage, it applies backpressure and reports last-round and error conditions.

## Interface
- WORD, 32, bits per column word
- NB, 4, columns per state; state width W = WORD*NB
- NR_MAX, 14, highest round index storable; key store depth NR_MAX+1
- RW, $clog2(NR_MAX+1), round-index width
- clk  in  1  clock; all logic on posedge clk
- rst  in  1  one clock; reset is synchronous and active-low (rst=0 resets on the next posedge clk)
- i_key_we  in  1  round-key write strobe
- i_key_idx  in  RW  round-key slot to write
- i_key  in  W  round-key value
- i_cfg_we  in  1  write strobe for the round-count register
- i_cfg_nr  in  RW  number of rounds (10/12/14 for AES)
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept an input beat
- i_block  in  W  input state
- i_round  in  RW  round index of the input beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the output beat
- o_block  out  W  output state
- o_round  out  RW  round index carried with the beat
- o_last  out  1  o_round == configured NR
- o_err  out  1  round index invalid for this beat

## Operation
- Key store: NR_MAX+1 registers of W bits.
  - If i_key_we=1 and i_key_idx<=NR_MAX, slot i_key_idx <= i_key.
  - If i_key_idx>NR_MAX, the write is silently dropped.
- Config register nr: if i_cfg_we=1, nr <= i_cfg_nr. Legal range is 1..NR_MAX.
  - A write of 0 or of a value >NR_MAX is dropped and nr keeps its old value.
- Accept: a beat is accepted when i_valid && o_ready. On accept, the output register loads:
  - o_round <= i_round and o_last <= (i_round == nr).
  - If i_round > nr: o_block <= i_block unchanged and o_err <= 1.
  - Otherwise: o_block <= i_block ^ key[i_round] and o_err <= 0.
- Single output register with valid/ready handshake:
  - o_ready = !o_valid || i_ready (combinational from i_ready).
  - On accept, o_valid <= 1.
  - Else if i_ready, o_valid <= 0.
  - Else the output register holds all of o_valid, o_block, o_round, o_last and o_err unchanged.
- Simultaneous drain and fill (o_valid=1, i_ready=1, i_valid=1): the old beat leaves and the new beat loads in the same cycle, with no bubble.
- Key-write / read collision: a beat accepted in the same cycle as a write to slot i_round uses the old key. The new key applies from the next cycle.
- Cfg-write / accept collision: o_last and o_err for a beat accepted in the write cycle use the old nr.
- No internal round counter. Sequencing is the caller's responsibility, so interleaved blocks are allowed.

## Timing
- Latency: 1 cycle from accept to o_valid=1.
- Throughput: 1 beat per cycle while i_ready=1.
- Output stability: while o_valid=1 and i_ready=0, all outputs stay stable and no beat is lost.
- Reset values (on posedge clk with rst=0):
  - o_valid=0, o_block=0, o_round=0, o_last=0, o_err=0.
  - All key slots = 0.
  - nr = 10.
- Reset overrides any simultaneous key write, cfg write or accept.
- A beat in flight at reset is discarded.
- o_ready=1 in the cycle that rst is asserted.
- All writes and accepts are ignored while rst=0.

## Test plan
- FIPS-197 round 0:
  - Write key[0]=000102030405060708090a0b0c0d0e0f.
  - Send i_block=00112233445566778899aabbccddeeff, i_round=0, with i_ready=1.
  - Next cycle: o_valid=1, o_block=00102030405060708090a0b0c0d0e0f0, o_last=0, o_err=0.
- Backpressure:
  - Stream 4 beats (rounds 0..3), holding i_ready=0 for 3 cycles after the first output.
  - Required: o_ready=0 throughout the stall, o_block constant, and all 4 beats delivered in order with no duplicates.
- Last and error flags with nr=10 (after reset):
  - round 10 -> o_last=1.
  - Cfg write nr=14, then round 10 -> o_last=0 and round 14 -> o_last=1.
  - Cfg write nr=10, then round 12 -> o_err=1, o_block=i_block.
- Collision:
  - key[3]=A, then write key[3]=B in the same cycle a round-3 beat is accepted -> output uses A.
  - The next round-3 beat uses B.
  - A key write with idx 15 (NR_MAX=14) leaves all slots unchanged.
- Reset mid-stream:
  - Assert rst=0 for 1 cycle while o_valid=1 and i_ready=0.
  - Next cycle: o_valid=0, o_block=0.
  - A round-0 beat with i_block=X then yields o_block=X, since the key was cleared to 0.
